// File: rtl/alu_exec_unit.sv
// Registered execute-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish in one cycle; multiply is an iterative shift-add over WIDTH cycles.
module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             illegal,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_SLT = 4'b1010;
   localparam logic [3:0] OP_MUL = 4'b0110;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

   state_t           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             overflow_q, overflow_d;
   logic             illegal_q, illegal_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    count_q, count_d;

   logic [WIDTH-1:0] sum, diff, alu_res, acc_step;
   logic             alu_ovf, alu_ill, is_mul, accept, slt;

   // Single-cycle datapath, evaluated directly on the incoming operands
   always_comb begin
      sum     = a + b;
      diff    = a - b;
      slt     = $signed(a) < $signed(b);
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_ill = 1'b0;
      is_mul  = 1'b0;
      case (alu_ctrl)
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
         OP_MUL:  is_mul  = 1'b1;
         default: alu_ill = 1'b1;
      endcase
   end

   assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      zero_d      = zero_q;
      overflow_d  = overflow_q;
      illegal_d   = illegal_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      count_d     = count_q;
      case (state_q)
         S_IDLE: begin
            if (accept && !is_mul) begin
               result_d    = alu_res;
               zero_d      = (alu_res == '0);
               overflow_d  = alu_ovf;
               illegal_d   = alu_ill;
               out_valid_d = 1'b1;
            end else begin
               if (out_ready) out_valid_d = 1'b0;
               if (accept) begin
                  mcand_d  = a;
                  mplier_d = b;
                  acc_d    = '0;
                  count_d  = CW'(WIDTH);
                  state_d  = S_MUL;
               end
            end
         end
         S_MUL: begin
            if (out_ready) out_valid_d = 1'b0;
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q - CW'(1);
            // Last partial product: publish the truncated product directly
            if (count_q == CW'(1)) begin
               result_d    = acc_step;
               zero_d      = (acc_step == '0);
               overflow_d  = 1'b0;
               illegal_d   = 1'b0;
               out_valid_d = 1'b1;
               state_d     = S_HOLD;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         overflow_q  <= 1'b0;
         illegal_q   <= 1'b0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         overflow_q  <= overflow_d;
         illegal_q   <= illegal_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign overflow  = overflow_q;
   assign illegal   = illegal_q;
   assign busy      = (state_q == S_MUL);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed corner cases plus a randomized handshake
// stream scored against an arithmetic reference model.
module tb_alu_exec_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    alu_ctrl = 4'd0;
   logic [W-1:0]  a_in = '0;
   logic [W-1:0]  b_in = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  result;
   logic          zero, overflow, illegal, busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_exec_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_ctrl(alu_ctrl), .a(a_in), .b(b_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .overflow(overflow),
      .illegal(illegal), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Reference: {illegal, overflow, zero, result} from plain integer arithmetic
   function automatic logic [34:0] model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
      longint      sx, sy, s;
      logic [63:0] p;
      logic [31:0] r;
      logic        o, il;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r  = '0;
      o  = 1'b0;
      il = 1'b0;
      case (c)
         4'd0:  begin s = sx + sy; r = x + y; o = (s != longint'($signed(r))); end
         4'd2:  begin s = sx - sy; r = x - y; o = (s != longint'($signed(r))); end
         4'd4:  r = x & y;
         4'd5:  r = x | y;
         4'd10: r = (sx < sy) ? 32'd1 : 32'd0;
         4'd6:  begin p = {32'd0, x} * {32'd0, y}; r = p[31:0]; end
         default: il = 1'b1;
      endcase
      return {il, o, (r == 32'd0), r};
   endfunction

   task automatic do_op(input string tag, input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
      logic [34:0] e;
      int          cyc;
      bit          rdy_seen;
      e = model(c, x, y);
      @(negedge clk);
      in_valid = 1'b1; alu_ctrl = c; a_in = x; b_in = y; out_ready = 1'b1;
      #1 chk({tag, "_in_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      if (c == 4'd6) begin
         chk({tag, "_busy_hi"}, busy, 1);
         cyc = 0;
         rdy_seen = 1'b0;
         while (!out_valid && cyc < 64) begin
            if (in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            cyc++;
         end
         chk({tag, "_latency"}, cyc, 32);
         chk({tag, "_rdy_low"}, rdy_seen, 0);
         chk({tag, "_busy_lo"}, busy, 0);
      end
      chk({tag, "_valid"}, out_valid, 1);
      chk(tag, {illegal, overflow, zero, result}, e);
   endtask

   logic [3:0]  ops [6] = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd10, 4'd6};
   logic [31:0] spec_vals [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

   function automatic logic [31:0] pick_operand();
      if ($urandom_range(3) == 0) return spec_vals[$urandom_range(4)];
      return $urandom;
   endfunction

   initial begin
      logic [34:0] sbq[$];
      int          cnt;
      bit          acc, cons;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_outputs", {out_valid, busy, illegal, overflow, zero, result}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", in_ready, 1);

      do_op("add_5_7",   4'd0, 32'd5, 32'd7);
      do_op("sub_3_3",   4'd2, 32'd3, 32'd3);
      do_op("add_ovf",   4'd0, 32'h7FFF_FFFF, 32'd1);
      do_op("sub_ovf",   4'd2, 32'h8000_0000, 32'd1);
      do_op("slt_neg",   4'd10, 32'h8000_0000, 32'h7FFF_FFFF);
      do_op("slt_pos",   4'd10, 32'd1, 32'hFFFF_FFFF);
      do_op("mul_6_7",   4'd6, 32'd6, 32'd7);
      do_op("mul_neg",   4'd6, 32'hFFFF_FFFF, 32'd2);
      do_op("illegal",   4'hF, 32'd9, 32'd9);
      do_op("add_clr",   4'd0, 32'd1, 32'd2);

      // Backpressure, then a pending AND accepted as the held result drains
      @(negedge clk);
      in_valid = 1'b1; alu_ctrl = 4'd0; a_in = 32'd10; b_in = 32'd20; out_ready = 1'b0;
      @(negedge clk);
      alu_ctrl = 4'd4; a_in = 32'hF0; b_in = 32'h3C;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_hold", {out_valid, result}, {1'b1, 32'd30});
         chk("bp_in_ready", in_ready, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1 chk("bp_release_rdy", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_no_bubble", {out_valid, result}, {1'b1, 32'h30});

      // Reset in the middle of a multiply
      @(negedge clk);
      in_valid = 1'b1; alu_ctrl = 4'd6; a_in = 32'd123; b_in = 32'd456;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (22) @(negedge clk);
      chk("mulrst_busy_before", busy, 1);
      rst_n = 1'b0;
      #1 chk("mulrst_outputs", {out_valid, busy, illegal, overflow, zero, result}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mulrst_in_ready", in_ready, 1);
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid || busy) cnt++;
      end
      chk("mulrst_no_result", cnt, 0);

      // Randomized stream with random backpressure, scored in order
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         if (!in_valid || acc) begin
            in_valid = ($urandom_range(3) != 0);
            alu_ctrl = ($urandom_range(7) == 0) ? 4'($urandom) : ops[$urandom_range(5)];
            a_in = pick_operand();
            b_in = pick_operand();
         end
         out_ready = ($urandom_range(3) != 0);
         #1;
         acc  = in_valid && in_ready;
         cons = out_valid && out_ready;
         if (cons) begin
            if (sbq.size() == 0) chk("stream_spurious", 1, 0);
            else chk("stream", {illegal, overflow, zero, result}, sbq.pop_front());
         end
         if (acc) sbq.push_back(model(alu_ctrl, a_in, b_in));
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      cnt = 0;
      while (sbq.size() != 0 && cnt < 200) begin
         #1;
         if (out_valid) chk("stream_drain", {illegal, overflow, zero, result}, sbq.pop_front());
         @(negedge clk);
         cnt++;
      end
      chk("stream_sb_empty", sbq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
